// File: rtl/instr_fetcher_pkg.sv
// instr_fetcher_pkg: shared widths, opcodes, fetch-queue entry type and immediate decoders.
package instr_fetcher_pkg;
    localparam int AddrWidth      = 32;
    localparam int InstrWidth     = 32;
    localparam int IfqDepthDef    = 8;
    localparam int BhtEntriesDef  = 64;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic {S_IDLE, S_WAIT} fetch_state_e;

    typedef struct packed {
        logic [InstrWidth-1:0] instr;
        logic [AddrWidth-1:0]  pc;
        logic                  pred;
    } iq_entry_t;

    // takes instr[31:12]
    function automatic logic [AddrWidth-1:0] j_imm(input logic [19:0] f);
        return {{11{f[19]}}, f[19], f[7:0], f[8], f[18:9], 1'b0};
    endfunction

    // takes instr[31:25] and instr[11:7]
    function automatic logic [AddrWidth-1:0] b_imm(input logic [6:0] hi, input logic [4:0] lo);
        return {{19{hi[6]}}, hi[6], lo[0], hi[5:0], lo[4:1], 1'b0};
    endfunction
endpackage

// File: rtl/instr_fetcher_bht.sv
// if_bht: table of 2-bit saturating branch counters, reset to weakly-not-taken.
// A same-cycle update and lookup of one entry returns the pre-update counter.
module if_bht
    import instr_fetcher_pkg::*;
#(
    parameter int BHT_ENTRIES = BhtEntriesDef,
    parameter int BW = $clog2(BHT_ENTRIES)
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          rdy_in,
    input  logic [BW-1:0] lkup_idx_in,
    output logic          lkup_taken_out,
    input  logic          upd_en_in,
    input  logic [BW-1:0] upd_idx_in,
    input  logic          upd_taken_in
);
    logic [BHT_ENTRIES-1:0][1:0] ctr_q, ctr_d;
    logic [1:0] cur;

    always_comb begin
        ctr_d = ctr_q;
        cur = ctr_q[upd_idx_in];
        if (upd_en_in)
            ctr_d[upd_idx_in] = upd_taken_in ? (cur == 2'd3 ? cur : cur + 2'd1)
                                             : (cur == 2'd0 ? cur : cur - 2'd1);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) ctr_q <= {BHT_ENTRIES{2'b01}};
        else if (rdy_in) ctr_q <= ctr_d;
    end

    assign lkup_taken_out = ctr_q[lkup_idx_in][1];
endmodule

// File: rtl/instr_fetcher.sv
// instr_fetcher: single-outstanding I-cache fetcher feeding a circular instruction queue.
// Define IF_BHT_EN to predict conditional branches with the if_bht counter table.
module instr_fetcher
    import instr_fetcher_pkg::*;
#(
    parameter int IFQ_DEPTH   = IfqDepthDef,
    parameter int BHT_ENTRIES = BhtEntriesDef
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    output logic                  if_to_icache_en_out,
    output logic [AddrWidth-1:0]  if_a_out,
    input  logic                  icache_to_if_en_in,
    input  logic [InstrWidth-1:0] if_d_in,
    output logic                  iq_en_out,
    output logic [InstrWidth-1:0] iq_instr_out,
    output logic [AddrWidth-1:0]  iq_pc_out,
    output logic                  iq_pred_taken_out,
    input  logic                  iq_rd_in,
    input  logic                  clear_branch_in,
    input  logic [AddrWidth-1:0]  clear_pc_in,
    input  logic                  bp_upd_en_in,
    input  logic [AddrWidth-1:0]  bp_upd_pc_in,
    input  logic                  bp_upd_taken_in
);
    localparam int QW = $clog2(IFQ_DEPTH);
    localparam int BW = $clog2(BHT_ENTRIES);
    localparam logic [QW:0] LAST = (QW+1)'(IFQ_DEPTH - 1);

    fetch_state_e          state_q, state_d;
    logic [AddrWidth-1:0]  pc_q, pc_d, addr_q, addr_d, next_pc;
    logic                  req_q, req_d;
    logic [QW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
    logic [QW:0]           count_q, count_d;
    iq_entry_t             mem_q [IFQ_DEPTH];
    iq_entry_t             push_entry;
    logic                  pop, resp, issue, push, is_jal, br_taken, bht_taken, unused_bp;
    logic [BW-1:0]         lkup_idx, upd_idx;

    assign lkup_idx = pc_q[BW+1:2];
    assign upd_idx  = bp_upd_pc_in[BW+1:2];

`ifdef IF_BHT_EN
    if_bht #(.BHT_ENTRIES(BHT_ENTRIES)) u_bht (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .lkup_idx_in   (lkup_idx),
        .lkup_taken_out(bht_taken),
        .upd_en_in     (bp_upd_en_in),
        .upd_idx_in    (upd_idx),
        .upd_taken_in  (bp_upd_taken_in)
    );
    assign unused_bp = ^{bp_upd_pc_in[AddrWidth-1:BW+2], bp_upd_pc_in[1:0]};
`else
    assign bht_taken = 1'b0;
    assign unused_bp = ^{bp_upd_en_in, bp_upd_taken_in, bp_upd_pc_in, lkup_idx, upd_idx};
`endif

    assign is_jal   = if_d_in[6:0] == OPC_JAL;
    assign br_taken = (if_d_in[6:0] == OPC_BRANCH) && bht_taken;
    assign next_pc  = is_jal   ? pc_q + j_imm(if_d_in[31:12])
                    : br_taken ? pc_q + b_imm(if_d_in[31:25], if_d_in[11:7])
                    : pc_q + 32'd4;
    assign push_entry = '{instr: if_d_in, pc: pc_q, pred: is_jal || br_taken};

    // a response is only legal once the request pulse has dropped
    assign pop   = iq_rd_in && count_q != '0;
    assign resp  = state_q == S_WAIT && !req_q && icache_to_if_en_in;
    assign issue = state_q == S_IDLE && (count_q < LAST || (count_q == LAST && iq_rd_in));

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        req_d   = 1'b0;
        addr_d  = addr_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        push    = 1'b0;
        if (clear_branch_in) begin
            state_d = S_IDLE;
            pc_d    = clear_pc_in;
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            push = resp;
            if (issue) begin
                req_d   = 1'b1;
                addr_d  = pc_q;
                state_d = S_WAIT;
            end
            if (resp) begin
                pc_d    = next_pc;
                state_d = S_IDLE;
            end
            wptr_d  = wptr_q + QW'(push);
            rptr_d  = rptr_q + QW'(pop);
            count_d = count_q + (QW+1)'(push) - (QW+1)'(pop);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            req_q   <= 1'b0;
            addr_q  <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (rdy_in) begin
            state_q <= state_d;
            pc_q    <= pc_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in && rdy_in && push) mem_q[wptr_q] <= push_entry;
    end

    assign if_to_icache_en_out = req_q;
    assign if_a_out            = addr_q;
    assign iq_en_out           = count_q != '0;
    assign iq_instr_out        = mem_q[rptr_q].instr;
    assign iq_pc_out           = mem_q[rptr_q].pc;
    assign iq_pred_taken_out   = mem_q[rptr_q].pred;
endmodule

// File: tb/tb_instr_fetcher.sv
// tb_instr_fetcher: transaction-level queue model checked every cycle, plus directed literal checks.
module tb_instr_fetcher;
    localparam int D = 8;
    localparam int B = 64;
    localparam logic [31:0] ADDI = 32'h00100093;
    localparam logic [31:0] JAL  = 32'h0200006F;
    localparam logic [31:0] BEQ  = 32'hFE000CE3;

    logic clk_in = 1'b0;
    logic rst_in, rdy_in, if_to_icache_en_out, icache_to_if_en_in, iq_en_out, iq_pred_taken_out;
    logic iq_rd_in, clear_branch_in, bp_upd_en_in, bp_upd_taken_in;
    logic [31:0] if_a_out, if_d_in, iq_instr_out, iq_pc_out, clear_pc_in, bp_upd_pc_in;

    always #5 clk_in = ~clk_in;

    instr_fetcher #(.IFQ_DEPTH(D), .BHT_ENTRIES(B)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .if_to_icache_en_out(if_to_icache_en_out), .if_a_out(if_a_out),
        .icache_to_if_en_in(icache_to_if_en_in), .if_d_in(if_d_in),
        .iq_en_out(iq_en_out), .iq_instr_out(iq_instr_out), .iq_pc_out(iq_pc_out),
        .iq_pred_taken_out(iq_pred_taken_out), .iq_rd_in(iq_rd_in),
        .clear_branch_in(clear_branch_in), .clear_pc_in(clear_pc_in),
        .bp_upd_en_in(bp_upd_en_in), .bp_upd_pc_in(bp_upd_pc_in), .bp_upd_taken_in(bp_upd_taken_in)
    );

    int n_chk = 0, n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {logic [31:0] instr; logic [31:0] pc; logic pred;} ent_t;
    ent_t mq[$];
    logic [31:0] m_pc, m_addr, m_npc;
    bit m_busy, m_pulse, m_valid, m_pred, m_pop, m_resp, m_issue;
    int m_bht[B];

    function automatic void predict(input logic [31:0] pc, input logic [31:0] ins,
                                    output logic [31:0] npc, output bit pred);
        int off;
        npc = pc + 32'd4;
        pred = 0;
        if (ins[6:0] == 7'h6F) begin
            off = int'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
            npc = pc + 32'(off);
            pred = 1;
        end
`ifdef IF_BHT_EN
        if (ins[6:0] == 7'h63 && m_bht[(pc >> 2) % B] >= 2) begin
            off = int'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
            npc = pc + 32'(off);
            pred = 1;
        end
`endif
    endfunction

    always @(posedge clk_in) begin
        if (rst_in) begin
            mq.delete();
            m_pc = 0; m_addr = 0; m_busy = 0; m_pulse = 0; m_valid = 1;
            foreach (m_bht[i]) m_bht[i] = 1;
        end else if (rdy_in) begin
            m_pop   = iq_rd_in && mq.size() > 0;
            m_resp  = m_busy && !m_pulse && icache_to_if_en_in;
            m_issue = !m_busy && (mq.size() < D-1 || (mq.size() == D-1 && iq_rd_in));
            if (clear_branch_in) begin
                mq.delete();
                m_pc = clear_pc_in; m_busy = 0; m_pulse = 0;
            end else begin
                if (m_pop) void'(mq.pop_front());
                if (m_resp) begin
                    predict(m_pc, if_d_in, m_npc, m_pred);
                    mq.push_back('{if_d_in, m_pc, m_pred});
                    m_pc = m_npc; m_busy = 0;
                end
                m_pulse = m_issue;
                if (m_issue) begin m_addr = m_pc; m_busy = 1; end
            end
`ifdef IF_BHT_EN
            if (bp_upd_en_in) begin
                int k;
                k = (bp_upd_pc_in >> 2) % B;
                m_bht[k] = bp_upd_taken_in ? (m_bht[k] == 3 ? 3 : m_bht[k] + 1)
                                           : (m_bht[k] == 0 ? 0 : m_bht[k] - 1);
            end
`endif
        end
    end

    always @(negedge clk_in) begin
        if (m_valid) begin
            check("req_pulse", {31'd0, if_to_icache_en_out}, {31'd0, m_pulse});
            check("req_addr", if_a_out, m_addr);
            check("iq_en", {31'd0, iq_en_out}, {31'd0, mq.size() != 0});
            if (mq.size() != 0) begin
                check("head_instr", iq_instr_out, mq[0].instr);
                check("head_pc", iq_pc_out, mq[0].pc);
                check("head_pred", {31'd0, iq_pred_taken_out}, {31'd0, mq[0].pred});
            end
        end
    end

    // ---------------- icache responder / clear driver ----------------
    int lat = 1, pend = 0;
    logic [31:0] pend_a, clr_addr;
    bit jal_en, clr_req, clr_any;
    logic [31:0] pa[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h40) return BEQ;
        if (jal_en && a == 32'h10) return JAL;
        return ADDI;
    endfunction

    initial begin
        icache_to_if_en_in = 0; if_d_in = 0; clear_branch_in = 0; clear_pc_in = 0;
        forever begin
            @(negedge clk_in);
            icache_to_if_en_in = 0;
            clear_branch_in = 0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin icache_to_if_en_in = 1; if_d_in = mem_word(pend_a); end
            end
            if (clr_req && (clr_any || icache_to_if_en_in)) begin
                clear_branch_in = 1; clear_pc_in = clr_addr; clr_req = 0; pend = 0;
            end
            if (if_to_icache_en_out === 1'b1) begin
                pend = lat; pend_a = if_a_out; pa.push_back(if_a_out);
            end
        end
    end

    // ---------------- directed sequence ----------------
    task automatic tick(input int n);
        repeat (n) begin @(posedge clk_in); #2; end
    endtask

    task automatic do_reset();
        rst_in = 1; tick(2);
        pa.delete(); pend = 0; rst_in = 0;
    endtask

    initial begin
        int idx;
        bit hit;
        rst_in = 1; rdy_in = 1; iq_rd_in = 0; bp_upd_en_in = 0; bp_upd_pc_in = 0; bp_upd_taken_in = 0;
        jal_en = 0; clr_req = 0; clr_any = 0; clr_addr = 0;
        do_reset();
        check("rst_pulse", {31'd0, if_to_icache_en_out}, 0);
        check("rst_addr", if_a_out, 0);
        check("rst_iq_en", {31'd0, iq_en_out}, 0);
        tick(1);
        check("first_req_pulse", {31'd0, if_to_icache_en_out}, 1);
        check("first_req_addr", if_a_out, 0);
        tick(39);
        check("fill_req_count", pa.size(), 7);
        check("fill_last_pc", pa.size() > 6 ? pa[6] : 32'hX, 32'h18);
        check("fill_head_pc", iq_pc_out, 0);
        check("fill_head_instr", iq_instr_out, ADDI);
        check("fill_no_pulse", {31'd0, if_to_icache_en_out}, 0);

        // frozen: pops and fetches are ignored
        rdy_in = 0; iq_rd_in = 1; tick(5);
        check("frz_head_pc", iq_pc_out, 0);
        check("frz_no_pulse", {31'd0, if_to_icache_en_out}, 0);
        rdy_in = 1; iq_rd_in = 0; tick(1);

        // pops against slower responses, through pointer wrap
        lat = 2;
        for (int i = 0; i < 60; i++) begin iq_rd_in = (i % 3) != 0; tick(1); end
        iq_rd_in = 0; tick(30);
        lat = 1;

        // JAL redirect
        jal_en = 1;
        do_reset();
        tick(40);
        check("jal_req_count", pa.size(), 7);
        check("jal_pc", pa.size() > 5 ? pa[4] : 32'hX, 32'h10);
        check("jal_target", pa.size() > 5 ? pa[5] : 32'hX, 32'h30);
        iq_rd_in = 1; tick(4); iq_rd_in = 0;
        check("jal_head_pc", iq_pc_out, 32'h10);
        check("jal_head_instr", iq_instr_out, JAL);
        check("jal_head_pred", {31'd0, iq_pred_taken_out}, 1);
        jal_en = 0;
        tick(10);

        // mispredict flush coinciding with a response
        do_reset();
        tick(7);
        clr_addr = 32'h100; clr_any = 0; clr_req = 1;
        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin @(posedge clk_in); hit = clear_branch_in; end
        #2;
        check("clr_seen", {31'd0, hit}, 1);
        check("clr_iq_en", {31'd0, iq_en_out}, 0);
        check("clr_no_pulse", {31'd0, if_to_icache_en_out}, 0);
        tick(1);
        check("clr_req_pulse", {31'd0, if_to_icache_en_out}, 1);
        check("clr_req_addr", if_a_out, 32'h100);
        tick(10);

        // predictor training on 0x40 during a redirect to 0x40
        rst_in = 1; tick(2);
        pa.delete(); pend = 0; rst_in = 0;
        bp_upd_en_in = 1; bp_upd_pc_in = 32'h40; bp_upd_taken_in = 1;
        clr_addr = 32'h40; clr_any = 1; clr_req = 1;
        tick(2);
        bp_upd_en_in = 0; clr_any = 0;
        tick(12);
        idx = -1;
        foreach (pa[i]) if (idx < 0 && pa[i] == 32'h40) idx = i;
        check("beq_req_seen", {31'd0, idx >= 0 && idx + 1 < pa.size()}, 1);
`ifdef IF_BHT_EN
        check("beq_next_req", (idx >= 0 && idx + 1 < pa.size()) ? pa[idx+1] : 32'hX, 32'h38);
        check("beq_head_pred", {31'd0, iq_pred_taken_out}, 1);
`else
        check("beq_next_req", (idx >= 0 && idx + 1 < pa.size()) ? pa[idx+1] : 32'hX, 32'h44);
        check("beq_head_pred", {31'd0, iq_pred_taken_out}, 0);
`endif
        check("beq_head_pc", iq_pc_out, 32'h40);
        check("beq_head_instr", iq_instr_out, BEQ);

        // untrain back through saturation while fetching continues
        bp_upd_en_in = 1; bp_upd_taken_in = 0;
        iq_rd_in = 1; tick(5);
        bp_upd_en_in = 0; tick(25);
        iq_rd_in = 0; tick(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
